fft_icore2_pipe: RTL and testbench

- Pipelined radix-2 decimation-in-frequency (DIF) butterfly for the 64-point IFFT/inverse path.
- Mirrors the forward DIT butterfly in the other direction:
  - upper output = a + b
  - lower output = (a − b) · conj(w)
- 3 register stages with valid/ready flow control, so a streaming IFFT stage controller can drive it at one butterfly per cycle with downstream backpressure.
- Widths come from fft_defines.vh: DATA_WID, WN_WID, ACC_LEN. Twiddle 1.0 = 1<<ACC_LEN.

---
 rtl/fft_icore2_pipe.sv | 155 +++++++++++++++
 tb/tb_fft_icore2_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_icore2_pipe.sv
// Pipelined radix-2 DIF butterfly for the inverse FFT path: upper = a+b, lower = (a-b)*conj(w).
// Optional FFT_IFFT_SCALE_EN halves every output (1/N normalisation across six stages).
`ifndef DATA_WID
`define DATA_WID 16
`endif
`ifndef WN_WID
`define WN_WID 16
`endif
`ifndef ACC_LEN
`define ACC_LEN 14
`endif

module fft_icore2_pipe (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 fft_valid_i,
   output logic                 fft_ready_o,
   input  logic [`DATA_WID-1:0] fft_data_re1_i,
   input  logic [`DATA_WID-1:0] fft_data_im1_i,
   input  logic [`DATA_WID-1:0] fft_data_re2_i,
   input  logic [`DATA_WID-1:0] fft_data_im2_i,
   input  logic [`WN_WID-1:0]   fft_wn_re_i,
   input  logic [`WN_WID-1:0]   fft_wn_im_i,
   output logic                 fft_valid_o,
   input  logic                 fft_ready_i,
   output logic [`DATA_WID-1:0] fft_data_re1_o,
   output logic [`DATA_WID-1:0] fft_data_im1_o,
   output logic [`DATA_WID-1:0] fft_data_re2_o,
   output logic [`DATA_WID-1:0] fft_data_im2_o,
   output logic                 fft_ovf_o
);

   localparam int DW = `DATA_WID;
   localparam int WW = `WN_WID;
   localparam int AL = `ACC_LEN;
   localparam int SW = DW + 1;
   localparam int PW = DW + WW + 2;
`ifdef FFT_IFFT_SCALE_EN
   localparam int SH = AL + 1;
`else
   localparam int SH = AL;
`endif

   logic          rdy_q;
   logic          v1, v2, v3;
   logic          en1, en2, en3;
   logic          take;
   logic [SW-1:0] sr, si, dr, di;
   logic [WW-1:0] wr, wi;
   logic [PW-1:0] pr, pi, ur, ui;
   logic [PW-1:0] dr_x, di_x, wr_x, wi_x, sr_x, si_x;
   logic [PW-1:0] pr_n, pi_n, ur_n, ui_n;
   logic [DW:0]   r_ur, r_ui, r_pr, r_pi;

   // Round half toward +inf, then report whether the result fits DW bits; returns {ovf, value}.
   function automatic logic [DW:0] rnd(input logic [PW-1:0] x);
      logic [PW-1:0] s;
      logic [PW-1:0] y;
      logic          fits;
      s    = $signed(x) >>> SH;
      y    = s + {{(PW-1){1'b0}}, x[SH-1]};
      fits = (&y[PW-1:DW-1]) | ~(|y[PW-1:DW-1]);
      return {~fits, y[DW-1:0]};
   endfunction

   // Each stage may load when it is empty or its occupant leaves this cycle.
   always_comb begin
      en3         = !v3 || fft_ready_i;
      en2         = !v2 || en3;
      en1         = !v1 || en2;
      fft_ready_o = rdy_q && en1;
      fft_valid_o = v3;
      take        = fft_valid_i && fft_ready_o;
   end

   always_comb begin
      dr_x = {{(PW-SW){dr[SW-1]}}, dr};
      di_x = {{(PW-SW){di[SW-1]}}, di};
      sr_x = {{(PW-SW){sr[SW-1]}}, sr};
      si_x = {{(PW-SW){si[SW-1]}}, si};
      wr_x = {{(PW-WW){wr[WW-1]}}, wr};
      wi_x = {{(PW-WW){wi[WW-1]}}, wi};
      pr_n = dr_x * wr_x + di_x * wi_x;
      pi_n = di_x * wr_x - dr_x * wi_x;
      ur_n = sr_x << AL;
      ui_n = si_x << AL;
      r_ur = rnd(ur);
      r_ui = rnd(ui);
      r_pr = rnd(pr);
      r_pi = rnd(pi);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q <= 1'b0;
         v1    <= 1'b0;
         sr    <= '0;
         si    <= '0;
         dr    <= '0;
         di    <= '0;
         wr    <= '0;
         wi    <= '0;
      end else begin
         rdy_q <= 1'b1;
         if (en1) v1 <= take;
         if (take) begin
            sr <= {fft_data_re1_i[DW-1], fft_data_re1_i} + {fft_data_re2_i[DW-1], fft_data_re2_i};
            si <= {fft_data_im1_i[DW-1], fft_data_im1_i} + {fft_data_im2_i[DW-1], fft_data_im2_i};
            dr <= {fft_data_re1_i[DW-1], fft_data_re1_i} - {fft_data_re2_i[DW-1], fft_data_re2_i};
            di <= {fft_data_im1_i[DW-1], fft_data_im1_i} - {fft_data_im2_i[DW-1], fft_data_im2_i};
            wr <= fft_wn_re_i;
            wi <= fft_wn_im_i;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2 <= 1'b0;
         pr <= '0;
         pi <= '0;
         ur <= '0;
         ui <= '0;
      end else begin
         if (en2) v2 <= v1;
         if (en2 && v1) begin
            pr <= pr_n;
            pi <= pi_n;
            ur <= ur_n;
            ui <= ui_n;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v3             <= 1'b0;
         fft_data_re1_o <= '0;
         fft_data_im1_o <= '0;
         fft_data_re2_o <= '0;
         fft_data_im2_o <= '0;
         fft_ovf_o      <= 1'b0;
      end else begin
         if (en3) v3 <= v2;
         if (en3 && v2) begin
            fft_data_re1_o <= r_ur[DW-1:0];
            fft_data_im1_o <= r_ui[DW-1:0];
            fft_data_re2_o <= r_pr[DW-1:0];
            fft_data_im2_o <= r_pi[DW-1:0];
            if (r_ur[DW] | r_ui[DW] | r_pr[DW] | r_pi[DW]) fft_ovf_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fft_icore2_pipe.sv
// Directed self-checking bench for fft_icore2_pipe; expectations follow FFT_IFFT_SCALE_EN.
`ifndef DATA_WID
`define DATA_WID 16
`endif
`ifndef WN_WID
`define WN_WID 16
`endif
`ifndef ACC_LEN
`define ACC_LEN 14
`endif

module tb_fft_icore2_pipe;

   localparam int DW = `DATA_WID;
   localparam int WW = `WN_WID;
   localparam int K  = 1 << `ACC_LEN;
   localparam int MX = (1 << (DW-1)) - 1;
`ifdef FFT_IFFT_SCALE_EN
   localparam bit SC = 1'b1;
`else
   localparam bit SC = 1'b0;
`endif
   localparam int D = SC ? 2 : 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          fft_valid_i, fft_ready_o, fft_valid_o, fft_ready_i, fft_ovf_o;
   logic [DW-1:0] fft_data_re1_i, fft_data_im1_i, fft_data_re2_i, fft_data_im2_i;
   logic [WW-1:0] fft_wn_re_i, fft_wn_im_i;
   logic [DW-1:0] fft_data_re1_o, fft_data_im1_o, fft_data_re2_o, fft_data_im2_o;

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   fft_icore2_pipe dut (
      .clk(clk), .rst_n(rst_n),
      .fft_valid_i(fft_valid_i), .fft_ready_o(fft_ready_o),
      .fft_data_re1_i(fft_data_re1_i), .fft_data_im1_i(fft_data_im1_i),
      .fft_data_re2_i(fft_data_re2_i), .fft_data_im2_i(fft_data_im2_i),
      .fft_wn_re_i(fft_wn_re_i), .fft_wn_im_i(fft_wn_im_i),
      .fft_valid_o(fft_valid_o), .fft_ready_i(fft_ready_i),
      .fft_data_re1_o(fft_data_re1_o), .fft_data_im1_o(fft_data_im1_o),
      .fft_data_re2_o(fft_data_re2_o), .fft_data_im2_o(fft_data_im2_o),
      .fft_ovf_o(fft_ovf_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input int ar, input int ai, input int br, input int bi,
                        input int wr, input int wi);
      fft_data_re1_i = DW'(ar);
      fft_data_im1_i = DW'(ai);
      fft_data_re2_i = DW'(br);
      fft_data_im2_i = DW'(bi);
      fft_wn_re_i    = WW'(wr);
      fft_wn_im_i    = WW'(wi);
   endtask

   // One beat with ready_i high; lat = cycles from the handshake cycle to valid_o.
   task automatic send_one(input int ar, input int ai, input int br, input int bi,
                           input int wr, input int wi, output int lat,
                           output int o1r, output int o1i, output int o2r, output int o2i,
                           output int ov);
      lat = -1; o1r = 0; o1i = 0; o2r = 0; o2i = 0; ov = 0;
      @(posedge clk); #1;
      fft_ready_i = 1'b1;
      drive(ar, ai, br, bi, wr, wi);
      fft_valid_i = 1'b1;
      @(negedge clk);
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         fft_valid_i = 1'b0;
         @(negedge clk);
         if (fft_valid_o) begin
            lat = c;
            o1r = $signed(fft_data_re1_o);
            o1i = $signed(fft_data_im1_o);
            o2r = $signed(fft_data_re2_o);
            o2i = $signed(fft_data_im2_o);
            ov  = int'(fft_ovf_o);
            break;
         end
      end
   endtask

   initial begin
      int lat, o1r, o1i, o2r, o2i, ov;
      int sent, rcv, acc, stalled_prev, saw_low, extra, stale;
      logic [4*DW:0] held;

      rst_n = 1'b0;
      fft_valid_i = 1'b0;
      fft_ready_i = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      #1;
      chk("rst_valid_o", int'(fft_valid_o), 0);
      chk("rst_ready_o", int'(fft_ready_o), 0);
      chk("rst_ovf", int'(fft_ovf_o), 0);
      chk("rst_re1", int'(fft_data_re1_o), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_rst", int'(fft_ready_o), 1);

      // identity twiddle
      send_one(100, 50, 20, -10, K, 0, lat, o1r, o1i, o2r, o2i, ov);
      chk("id_latency", lat, 3);
      chk("id_re1", o1r, 120 / D);
      chk("id_im1", o1i, 40 / D);
      chk("id_re2", o2r, 80 / D);
      chk("id_im2", o2i, 60 / D);
      chk("id_ovf", ov, 0);

      // w = -jK, conj(w) = +j
      send_one(100, 50, 20, -10, 0, -K, lat, o1r, o1i, o2r, o2i, ov);
      chk("tw_re1", o1r, 120 / D);
      chk("tw_im1", o1i, 40 / D);
      chk("tw_re2", o2r, -60 / D);
      chk("tw_im2", o2i, 80 / D);

      // rounding of half values
      send_one(3, 0, 0, 0, K / 2, 0, lat, o1r, o1i, o2r, o2i, ov);
      chk("rnd_pos_re1", o1r, SC ? 2 : 3);
      chk("rnd_pos_re2", o2r, SC ? 1 : 2);
      send_one(-3, 0, 0, 0, K / 2, 0, lat, o1r, o1i, o2r, o2i, ov);
      chk("rnd_neg_re1", o1r, SC ? -1 : -3);
      chk("rnd_neg_re2", o2r, -1);

      // streaming with a mid-stream stall
      sent = 0; rcv = 0; acc = 0; stalled_prev = 0; saw_low = 0; held = '0;
      for (int c = 0; c < 60 && rcv < 8; c++) begin
         @(posedge clk); #1;
         if (acc != 0) sent++;
         if (sent < 8) begin
            drive(20 * (sent + 1), 2 * (sent + 1), 2 * (sent + 1), 0, K, 0);
            fft_valid_i = 1'b1;
         end else begin
            fft_valid_i = 1'b0;
         end
         fft_ready_i = !(c >= 4 && c < 9);
         @(negedge clk);
         acc = int'(fft_valid_i && fft_ready_o);
         if (!fft_ready_o) saw_low = 1;
         if (stalled_prev != 0)
            chk("stall_hold", int'({fft_valid_o, fft_data_re1_o, fft_data_im1_o,
                                   fft_data_re2_o, fft_data_im2_o} == held), 1);
         stalled_prev = int'(fft_valid_o && !fft_ready_i);
         held = {fft_valid_o, fft_data_re1_o, fft_data_im1_o, fft_data_re2_o, fft_data_im2_o};
         if (fft_valid_o && fft_ready_i) begin
            rcv++;
            chk("strm_re1", $signed(fft_data_re1_o), 22 * rcv / D);
            chk("strm_im1", $signed(fft_data_im1_o), 2 * rcv / D);
            chk("strm_re2", $signed(fft_data_re2_o), 18 * rcv / D);
            chk("strm_im2", $signed(fft_data_im2_o), 2 * rcv / D);
         end
      end
      chk("strm_count", rcv, 8);
      chk("strm_ready_drop", saw_low, 1);
      @(posedge clk); #1;
      fft_valid_i = 1'b0;
      fft_ready_i = 1'b1;
      extra = 0;
      repeat (5) begin
         @(negedge clk);
         if (fft_valid_o) extra++;
      end
      chk("strm_no_extra", extra, 0);

      // overflow
      send_one(MX, 0, MX, 0, K, 0, lat, o1r, o1i, o2r, o2i, ov);
      chk("ovf_re1", o1r, SC ? MX : -2);
      chk("ovf_re2", o2r, 0);
      chk("ovf_flag", ov, SC ? 0 : 1);
      send_one(100, 50, 20, -10, K, 0, lat, o1r, o1i, o2r, o2i, ov);
      chk("ovf_sticky", ov, SC ? 0 : 1);
      chk("ovf_clean_re1", o1r, 120 / D);

      // asynchronous reset with three beats in flight
      @(posedge clk); #1;
      fft_ready_i = 1'b0;
      drive(100, 50, 20, -10, K, 0);
      fft_valid_i = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      chk("mid_valid_before", int'(fft_valid_o), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_valid_o", int'(fft_valid_o), 0);
      chk("mid_re1", int'(fft_data_re1_o), 0);
      chk("mid_im2", int'(fft_data_im2_o), 0);
      chk("mid_ovf", int'(fft_ovf_o), 0);
      chk("mid_ready_o", int'(fft_ready_o), 0);
      fft_valid_i = 1'b0;
      fft_ready_i = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("mid_ready_after", int'(fft_ready_o), 1);
      stale = 0;
      repeat (5) begin
         @(negedge clk);
         if (fft_valid_o) stale++;
      end
      chk("mid_no_stale", stale, 0);
      send_one(100, 50, 20, -10, K, 0, lat, o1r, o1i, o2r, o2i, ov);
      chk("mid_next_latency", lat, 3);
      chk("mid_next_re2", o2r, 80 / D);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
